// File: rtl/fifo_pop_ctrl_if.sv
// fifo_pop_ctrl_if
// Groups the FIFO read port and the downstream valid/ready stream of the
// read-side controller.
//   fifo_empty  FIFO empty flag                      (FIFO -> ctrl)
//   fifo_data   FIFO data_out, one cycle after read  (FIFO -> ctrl)
//   fifo_rd     FIFO read strobe                     (ctrl -> FIFO)
//   ready_in    downstream ready                     (consumer -> ctrl)
//   valid_out   stream word valid                    (ctrl -> consumer)
//   data_out_o  stream word                          (ctrl -> consumer)
// master: the controller side; slave: the FIFO/consumer environment.
interface fifo_pop_ctrl_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd;
    logic                  ready_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out_o;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        input  ready_in,
        output valid_out,
        output data_out_o
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        output ready_in,
        input  valid_out,
        input  data_out_o
    );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl
// Read-side controller for the 6-bit FIFO. Issues fifo_rd, captures the word
// that returns one cycle later into a 2-entry skid buffer and presents the
// head of that buffer on a valid/ready stream, sustaining one word per cycle.
// Ports:
//   clk        clock, rising edge
//   RESET      synchronous active-high reset
//   flush      synchronous discard of buffered and in-flight words
//   bus        fifo_pop_ctrl_if.master (FIFO read port + output stream)
//   occupancy  skid buffer entries held (0..2)
// Optional (macro FIFO_POP_COUNT_EN):
//   pop_count      accepted words, wraps, cleared by RESET and flush
//   underflow_err  sticky: fifo_rd while fifo_empty, cleared only by RESET
//
// state | meaning
// EMPTY | no word buffered (occ=0)
// ONE   | one word buffered, held in entry 0 (occ=1)
// TWO   | buffer full, head in entry 0, next in entry 1 (occ=2)
module fifo_pop_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int BUF_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            flush,
    fifo_pop_ctrl_if.master bus,
    output logic [1:0]      occupancy
`ifdef FIFO_POP_COUNT_EN
    ,
    output logic [15:0]     pop_count,
    output logic            underflow_err
`endif
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    state_t                state;
    logic                  inflight;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic [DATA_WIDTH-1:0] entry0_next;
    logic [DATA_WIDTH-1:0] entry1_next;
    logic                  pop;
    logic [2:0]            occ_sum;
    logic [1:0]            tail;

    assign pop = valid_q & bus.ready_in;

    // Occupancy after this edge; pop implies state != EMPTY, so no wrap.
    assign occ_sum = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};

    // Only read when the returning word is guaranteed a free slot.
    assign bus.fifo_rd    = ~RESET & ~flush & ~bus.fifo_empty & (occ_sum < DEPTH);
    assign bus.valid_out  = valid_q;
    assign bus.data_out_o = entry0;
    assign occupancy      = state;

    // Shift on pop first, then the captured word lands in the freed tail.
    always_comb begin
        entry0_next = entry0;
        entry1_next = entry1;
        tail        = state - {1'b0, pop};
        if (pop && state == TWO) begin
            entry0_next = entry1;
        end
        if (inflight) begin
            if (tail == 2'd0) begin
                entry0_next = bus.fifo_data;
            end else begin
                entry1_next = bus.fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state    <= EMPTY;
            inflight <= 1'b0;
            valid_q  <= 1'b0;
            entry0   <= '0;
            entry1   <= '0;
        end else if (flush) begin
            // Dropping inflight discards the word returning from last cycle's read.
            state    <= EMPTY;
            inflight <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_t'(occ_sum[1:0]);
            valid_q  <= (occ_sum != 3'd0);
            inflight <= bus.fifo_rd;
            entry0   <= entry0_next;
            entry1   <= entry1_next;
        end
    end

    always @(posedge clk) begin
        if (!RESET && !flush) begin
            assert (occ_sum <= DEPTH)
                else $error("fifo_pop_ctrl skid buffer overflow");
        end
    end

`ifdef FIFO_POP_COUNT_EN
    always_ff @(posedge clk) begin
        if (RESET) begin
            pop_count     <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (flush) begin
                pop_count <= '0;
            end else if (pop) begin
                pop_count <= pop_count + 16'd1;
            end
            if (bus.fifo_rd && bus.fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
module tb_fifo_pop_ctrl;
    localparam int DW = 6;

    logic       clk   = 1'b0;
    logic       RESET = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
`ifdef FIFO_POP_COUNT_EN
    logic [15:0] pop_count;
    logic        underflow_err;
`endif

    fifo_pop_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fifo_pop_ctrl #(
        .DATA_WIDTH(DW),
        .BUF_DEPTH (2)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
`ifdef FIFO_POP_COUNT_EN
        ,
        .pop_count     (pop_count),
        .underflow_err (underflow_err)
`endif
    );

    always #5 clk = ~clk;

    // environment FIFO contents, reference buffer and logs
    logic [DW-1:0] src[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] delivered[$];
    logic [DW-1:0] expq[$];
    bit            m_inflight;
    logic [DW-1:0] m_pending;
    logic [DW-1:0] next_fifo_data;
    bit            next_is_real;
    bit            check_zero_data;
    logic [15:0]   m_pop_count;
    int            n_pass;
    int            n_total;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the reference, advance it.
    task automatic step(input bit rst, input bit fl, input bit rdy, input string tag);
        bit exp_valid;
        bit pop;
        bit exp_rd;
        bit rd_s;
        int sum;
        bus.fifo_data  = next_is_real ? next_fifo_data : DW'($urandom);
        RESET          = rst;
        flush          = fl;
        bus.ready_in   = rdy;
        bus.fifo_empty = (src.size() == 0);
        #1;
        exp_valid = (mq.size() != 0);
        pop       = exp_valid && rdy;
        sum       = mq.size() + int'(m_inflight) - int'(pop);
        exp_rd    = !rst && !fl && (src.size() != 0) && (sum < 2);

        chk({tag, ".valid"}, 16'(bus.valid_out), 16'(exp_valid));
        chk({tag, ".occ"}, 16'(occupancy), 16'(mq.size()));
        if (exp_valid) chk({tag, ".data"}, 16'(bus.data_out_o), 16'(mq[0]));
        else if (check_zero_data) chk({tag, ".data0"}, 16'(bus.data_out_o), 16'd0);
        chk({tag, ".rd"}, 16'(bus.fifo_rd), 16'(exp_rd));
`ifdef FIFO_POP_COUNT_EN
        chk({tag, ".pop_count"}, pop_count, m_pop_count);
        chk({tag, ".underflow"}, 16'(underflow_err), 16'd0);
`endif
        rd_s = bus.fifo_rd;
        if (pop && !rst) delivered.push_back(bus.data_out_o);

        if (rst || fl) begin
            mq.delete();
            m_inflight = 1'b0;
            m_pop_count = 16'd0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_pop_count = m_pop_count + 16'd1;
            end
            if (m_inflight) mq.push_back(m_pending);
            m_inflight = exp_rd;
        end
        check_zero_data = rst ? 1'b1 : (check_zero_data && mq.size() == 0);

        // environment FIFO answers the sampled read one cycle later
        next_is_real = 1'b0;
        if (rd_s && src.size() != 0) begin
            next_fifo_data = src.pop_front();
            m_pending      = next_fifo_data;
            next_is_real   = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_delivered(input string tag);
        chk({tag, ".count"}, 16'(delivered.size()), 16'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < delivered.size())
                chk($sformatf("%s.word%0d", tag, i), 16'(delivered[i]), 16'(expq[i]));
        end
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        m_inflight      = 1'b0;
        m_pending       = '0;
        next_fifo_data  = '0;
        next_is_real    = 1'b0;
        check_zero_data = 1'b1;
        m_pop_count     = 16'd0;
        bus.ready_in    = 1'b0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_data   = '0;
        @(posedge clk);
        #1;

        // reset and basic read
        src.delete();
        src.push_back(6'b010010);
        repeat (2) step(1, 0, 1, "basic.rst");
        delivered.delete();
        repeat (5) step(0, 0, 1, "basic");
        expq.delete();
        expq.push_back(6'b010010);
        chk_delivered("basic");

        // streaming
        step(1, 0, 1, "stream.rst");
        delivered.delete();
        src.push_back(6'b100100);
        src.push_back(6'b110110);
        src.push_back(6'b010100);
        src.push_back(6'b110000);
        expq = src;
        repeat (8) step(0, 0, 1, "stream");
        chk_delivered("stream");

        // back-pressure
        step(1, 0, 0, "bp.rst");
        delivered.delete();
        for (int i = 0; i < 9; i++) src.push_back(DW'($urandom));
        expq = src;
        repeat (5) step(0, 0, 0, "bp.stall");
        chk("bp.full", 16'(occupancy), 16'd2);
        repeat (16) step(0, 0, 1, "bp.drain");
        chk_delivered("bp");

        // empty boundary
        step(1, 0, 0, "empty.rst");
        delivered.delete();
        repeat (8) step(0, 0, 1'($urandom_range(0, 1)), "empty");
        chk("empty.none", 16'(delivered.size()), 16'd0);

        // flush with a word in flight while occ=1
        step(1, 0, 1, "flush.rst");
        delivered.delete();
        src.push_back(6'h11);
        src.push_back(6'h22);
        src.push_back(6'h33);
        repeat (2) step(0, 0, 1, "flush.pre");
        step(0, 1, 1, "flush");
        chk("flush.no_inflight_word", 16'(bus.data_out_o == 6'h22), 16'd0);
        repeat (6) step(0, 0, 1, "flush.post");
        expq.delete();
        expq.push_back(6'h11);
        expq.push_back(6'h33);
        chk_delivered("flush");

        // reset mid-stream with occ=2
        step(1, 0, 0, "mid.rst0");
        for (int i = 1; i <= 6; i++) src.push_back(DW'(i * 9));
        repeat (4) step(0, 0, 0, "mid.stall");
        chk("mid.full", 16'(occupancy), 16'd2);
        step(1, 0, 0, "mid.rst");
        delivered.delete();
        expq = src;
        repeat (12) step(0, 0, 1, "mid.resume");
        chk_delivered("mid");

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) src.push_back(DW'($urandom));
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 3) != 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
